// File: rtl/exec_alu_if.sv
// Execute-stage ALU port bundle: micro-op inputs from schedule,
// registered results, flags and redirect toward Mem.
interface exec_alu_if;
  logic         enable;
  logic [9:0]   opcode;
  logic [63:0]  a;
  logic [63:0]  b;
  logic [63:0]  c;
  logic [63:0]  next_rip;
  logic         blocked;
  logic [127:0] result;
  logic [63:0]  rflags;
  logic         mem_valid;
  logic         branch;
  logic [63:0]  branch_rip;

  modport master (
    output enable, opcode, a, b, c,
    output next_rip, blocked,
    input  result, rflags, mem_valid,
    input  branch, branch_rip
  );

  modport slave (
    input  enable, opcode, a, b, c,
    input  next_rip, blocked,
    output result, rflags, mem_valid,
    output branch, branch_rip
  );
endinterface

// File: rtl/exec_alu.sv
// Execute-stage ALU: one micro-op per cycle, registered result/RFLAGS/redirect.
// Define ALU_MUL_EN to add IMUL (0x1AF) and MUL (0xF7) with 128-bit results.
module exec_alu (
  input  logic       clk,
  input  logic       reset,
  exec_alu_if.slave  alu
);

  logic [127:0] r_result;
  logic [63:0]  r_rflags;
  logic         r_mem_valid;
  logic         r_branch;
  logic [63:0]  r_branch_rip;

  logic [9:0]   w_op;
  logic [63:0]  w_a;
  logic [63:0]  w_b;
  logic [63:0]  w_rip;
  logic [5:0]   w_shamt;
  logic         w_sh_nz;
  logic         w_unused;

  assign w_op     = alu.opcode;
  assign w_a      = alu.a;
  assign w_b      = alu.b;
  assign w_rip    = alu.next_rip;
  assign w_shamt  = alu.c[5:0];
  assign w_sh_nz  = |w_shamt;
  assign w_unused = ^alu.c[63:6];

  logic w_add, w_sub, w_cmp, w_and, w_or, w_xor;
  logic w_test, w_pass_b, w_pass_a, w_shl, w_shr;
  logic w_jmp, w_jcc, w_link;

  assign w_add    = (w_op == 10'h001) || (w_op == 10'h003) ||
                    (w_op == 10'h005);
  assign w_sub    = (w_op == 10'h029) || (w_op == 10'h02B);
  assign w_cmp    = (w_op == 10'h039);
  assign w_and    = (w_op == 10'h021);
  assign w_or     = (w_op == 10'h009);
  assign w_xor    = (w_op == 10'h031);
  assign w_test   = (w_op == 10'h085);
  assign w_pass_b = (w_op == 10'h089) || (w_op == 10'h08B) ||
                    (w_op == 10'h0B8) || (w_op == 10'h050);
  assign w_pass_a = (w_op == 10'h090) || (w_op == 10'h058);
  assign w_shl    = (w_op == 10'h0C1);
  assign w_shr    = (w_op == 10'h0D3);
  assign w_jmp    = (w_op == 10'h0E9) || (w_op == 10'h0EB) ||
                    (w_op == 10'h0E8);
  assign w_jcc    = (w_op[9:4] == 6'h07);
  // Indirect call, RET and SYSCALL redirect later, in write-back
  assign w_link   = (w_op == 10'h310) || (w_op == 10'h0C3) ||
                    (w_op == 10'h105);

  logic [64:0] w_sum;
  logic [64:0] w_dif;
  logic        w_add_ov;
  logic        w_sub_ov;
  logic [64:0] w_shl_x;
  logic [64:0] w_shr_x;
  logic [63:0] w_tgt;

  assign w_sum    = {1'b0, w_a} + {1'b0, w_b};
  assign w_dif    = {1'b0, w_a} - {1'b0, w_b};
  assign w_add_ov = (w_a[63] == w_b[63]) &&
                    (w_sum[63] != w_a[63]);
  assign w_sub_ov = (w_a[63] != w_b[63]) &&
                    (w_dif[63] != w_a[63]);
  // Extra bit on the far side catches the last bit shifted out (CF)
  assign w_shl_x  = {1'b0, w_a} << w_shamt;
  assign w_shr_x  = {w_a, 1'b0} >> w_shamt;
  assign w_tgt    = w_rip + w_a;

`ifdef ALU_MUL_EN
  logic         w_imul, w_mul;
  logic [127:0] w_smul;
  logic [127:0] w_umul;
  logic         w_smul_ov;
  logic         w_umul_ov;

  assign w_imul    = (w_op == 10'h1AF);
  assign w_mul     = (w_op == 10'h0F7);
  assign w_smul    = {{64{w_a[63]}}, w_a} * {{64{w_b[63]}}, w_b};
  assign w_umul    = {64'd0, w_a} * {64'd0, w_b};
  assign w_smul_ov = (w_smul[127:64] != {64{w_smul[63]}});
  assign w_umul_ov = (w_umul[127:64] != 64'd0);
`endif

  logic w_of_f, w_cf_f, w_zf_f, w_sf_f, w_pf_f;
  logic w_cc_base;
  logic w_cc_true;

  assign w_cf_f = r_rflags[0];
  assign w_pf_f = r_rflags[2];
  assign w_zf_f = r_rflags[6];
  assign w_sf_f = r_rflags[7];
  assign w_of_f = r_rflags[11];

  // x86 cc: bits [3:1] pick the test, bit 0 negates it
  always_comb begin
    w_cc_base = 1'b0;
    unique case (w_op[3:1])
      3'd0: w_cc_base = w_of_f;
      3'd1: w_cc_base = w_cf_f;
      3'd2: w_cc_base = w_zf_f;
      3'd3: w_cc_base = w_cf_f | w_zf_f;
      3'd4: w_cc_base = w_sf_f;
      3'd5: w_cc_base = w_pf_f;
      3'd6: w_cc_base = w_sf_f ^ w_of_f;
      3'd7: w_cc_base = w_zf_f | (w_sf_f ^ w_of_f);
    endcase
  end

  assign w_cc_true = w_cc_base ^ w_op[0];

  logic [127:0] w_res;
  logic [63:0]  w_fl;
  logic         w_br;
  logic         w_setf;
  logic [63:0]  w_fr;
  logic         w_cf;
  logic         w_of;

  always_comb begin
    w_res  = '0;
    w_fl   = r_rflags;
    w_br   = 1'b0;
    w_setf = 1'b0;
    w_fr   = '0;
    w_cf   = 1'b0;
    w_of   = 1'b0;
    unique case (1'b1)
      w_add: begin
        w_res[63:0] = w_sum[63:0];
        w_setf      = 1'b1;
        w_fr        = w_sum[63:0];
        w_cf        = w_sum[64];
        w_of        = w_add_ov;
      end
      w_sub: begin
        w_res[63:0] = w_dif[63:0];
        w_setf      = 1'b1;
        w_fr        = w_dif[63:0];
        w_cf        = w_dif[64];
        w_of        = w_sub_ov;
      end
      w_cmp: begin
        w_res[63:0] = w_a;
        w_setf      = 1'b1;
        w_fr        = w_dif[63:0];
        w_cf        = w_dif[64];
        w_of        = w_sub_ov;
      end
      w_and: begin
        w_res[63:0] = w_a & w_b;
        w_setf      = 1'b1;
        w_fr        = w_a & w_b;
      end
      w_test: begin
        w_res[63:0] = w_a;
        w_setf      = 1'b1;
        w_fr        = w_a & w_b;
      end
      w_or: begin
        w_res[63:0] = w_a | w_b;
        w_setf      = 1'b1;
        w_fr        = w_a | w_b;
      end
      w_xor: begin
        w_res[63:0] = w_a ^ w_b;
        w_setf      = 1'b1;
        w_fr        = w_a ^ w_b;
      end
      w_pass_b: w_res[63:0] = w_b;
      w_pass_a: w_res[63:0] = w_a;
      w_shl: begin
        w_res[63:0] = w_shl_x[63:0];
        w_setf      = w_sh_nz;
        w_fr        = w_shl_x[63:0];
        w_cf        = w_shl_x[64];
        w_of        = w_shl_x[63] ^ w_shl_x[64];
      end
      w_shr: begin
        w_res[63:0] = w_shr_x[64:1];
        w_setf      = w_sh_nz;
        w_fr        = w_shr_x[64:1];
        w_cf        = w_shr_x[0];
        w_of        = w_a[63];
      end
      w_jmp: begin
        w_res[63:0] = w_rip;
        w_br        = 1'b1;
      end
      w_jcc: begin
        w_res[63:0] = w_rip;
        w_br        = w_cc_true;
      end
      w_link: w_res[63:0] = w_rip;
`ifdef ALU_MUL_EN
      w_imul: begin
        w_res    = w_smul;
        w_fl[0]  = w_smul_ov;
        w_fl[11] = w_smul_ov;
      end
      w_mul: begin
        w_res    = w_umul;
        w_fl[0]  = w_umul_ov;
        w_fl[11] = w_umul_ov;
      end
`endif
      default: w_res = '0;
    endcase
    if (w_setf) begin
      w_fl[0]  = w_cf;
      w_fl[2]  = ~^w_fr[7:0];
      w_fl[6]  = ~|w_fr;
      w_fl[7]  = w_fr[63];
      w_fl[11] = w_of;
    end
    w_fl[1] = 1'b1;
  end

  // A stall holds everything but the redirect, which must not repeat
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_result     <= '0;
      r_rflags     <= 64'h2;
      r_mem_valid  <= 1'b0;
      r_branch     <= 1'b0;
      r_branch_rip <= '0;
    end else if (alu.blocked) begin
      r_branch     <= 1'b0;
    end else if (alu.enable) begin
      r_result     <= w_res;
      r_rflags     <= w_fl;
      r_mem_valid  <= 1'b1;
      r_branch     <= w_br;
      if (w_br)
        r_branch_rip <= w_tgt;
    end else begin
      r_result     <= '0;
      r_mem_valid  <= 1'b0;
      r_branch     <= 1'b0;
    end
  end

  assign alu.result     = r_result;
  assign alu.rflags     = r_rflags;
  assign alu.mem_valid  = r_mem_valid;
  assign alu.branch     = r_branch;
  assign alu.branch_rip = r_branch_rip;

endmodule

// File: tb/tb_exec_alu.sv
// Scoreboard bench for exec_alu: expected results queued at issue,
// popped when mem_valid appears.
module tb_exec_alu;

  typedef struct {
    logic [127:0] res;
    logic [63:0]  fl;
    logic         br;
    logic [63:0]  rip;
  } exp_t;

  logic clk;
  logic reset;
  exec_alu_if bus();

  exec_alu dut (
    .clk   (clk),
    .reset (reset),
    .alu   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks;
  int          n_errors;
  exp_t        q[$];
  string       q_tag[$];
  logic [63:0] m_fl;
  bit          mon_en;

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic cc_taken(input logic [3:0] cc,
                                    input logic [63:0] f);
    logic cf, pf, zf, sf, of;
    cf = f[0]; pf = f[2]; zf = f[6];
    sf = f[7]; of = f[11];
    case (cc)
      4'h0: return of;
      4'h1: return !of;
      4'h2: return cf;
      4'h3: return !cf;
      4'h4: return zf;
      4'h5: return !zf;
      4'h6: return cf || zf;
      4'h7: return !(cf || zf);
      4'h8: return sf;
      4'h9: return !sf;
      4'hA: return pf;
      4'hB: return !pf;
      4'hC: return sf != of;
      4'hD: return sf == of;
      4'hE: return zf || (sf != of);
      default: return !(zf || (sf != of));
    endcase
  endfunction

  task automatic issue(input string tag, input logic [9:0] op,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] c, input logic [63:0] rip);
    exp_t        e;
    logic [63:0] r;
    logic        cf, of, setf;
    int          n;
    e.res = '0; e.fl = m_fl; e.br = 1'b0; e.rip = '0;
    r = '0; cf = 1'b0; of = 1'b0; setf = 1'b0;
    n = int'(c[5:0]);
    case (op)
      10'h001, 10'h003, 10'h005: begin
        r = a + b; cf = (r < a);
        of = (a[63] == b[63]) && (r[63] != a[63]);
        setf = 1'b1; e.res = {64'd0, r};
      end
      10'h029, 10'h02B, 10'h039: begin
        r = a - b; cf = (a < b);
        of = (a[63] != b[63]) && (r[63] != a[63]);
        setf = 1'b1;
        e.res = {64'd0, (op == 10'h039) ? a : r};
      end
      10'h021: begin r = a & b; setf = 1'b1; e.res = {64'd0, r}; end
      10'h085: begin r = a & b; setf = 1'b1; e.res = {64'd0, a}; end
      10'h009: begin r = a | b; setf = 1'b1; e.res = {64'd0, r}; end
      10'h031: begin r = a ^ b; setf = 1'b1; e.res = {64'd0, r}; end
      10'h089, 10'h08B, 10'h0B8, 10'h050: e.res = {64'd0, b};
      10'h090, 10'h058: e.res = {64'd0, a};
      10'h0C1: begin
        if (n == 0) e.res = {64'd0, a};
        else begin
          r = a << n; cf = a[64-n]; of = r[63] ^ cf;
          setf = 1'b1; e.res = {64'd0, r};
        end
      end
      10'h0D3: begin
        if (n == 0) e.res = {64'd0, a};
        else begin
          r = a >> n; cf = a[n-1]; of = a[63];
          setf = 1'b1; e.res = {64'd0, r};
        end
      end
      10'h0E9, 10'h0EB, 10'h0E8: begin
        e.res = {64'd0, rip}; e.br = 1'b1; e.rip = rip + a;
      end
      10'h310, 10'h0C3, 10'h105: e.res = {64'd0, rip};
`ifdef ALU_MUL_EN
      10'h1AF: begin
        e.res = 128'($signed(a)) * 128'($signed(b));
        cf = ($signed(e.res) > 128'sh7FFF_FFFF_FFFF_FFFF) ||
             ($signed(e.res) < -128'sh8000_0000_0000_0000);
        e.fl[0] = cf; e.fl[11] = cf;
      end
      10'h0F7: begin
        e.res = 128'(a) * 128'(b);
        cf = (e.res >= 128'h1_0000_0000_0000_0000);
        e.fl[0] = cf; e.fl[11] = cf;
      end
`endif
      default: begin
        if (op[9:4] == 6'h07) begin
          e.res = {64'd0, rip};
          e.br  = cc_taken(op[3:0], m_fl);
          e.rip = rip + a;
        end
      end
    endcase
    if (setf) begin
      e.fl[0]  = cf;
      e.fl[2]  = ~^r[7:0];
      e.fl[6]  = (r == 64'd0);
      e.fl[7]  = r[63];
      e.fl[11] = of;
    end
    m_fl = e.fl;
    @(negedge clk);
    bus.enable   = 1'b1;
    bus.opcode   = op;
    bus.a        = a;
    bus.b        = b;
    bus.c        = c;
    bus.next_rip = rip;
    q.push_back(e);
    q_tag.push_back(tag);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.enable = 1'b0;
  endtask

  initial begin
    exp_t  e;
    string t;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en && !reset && bus.mem_valid) begin
        if (q.size() == 0) begin
          chk("sb_underflow", 128'd1, 128'd0);
        end else begin
          e = q.pop_front();
          t = q_tag.pop_front();
          chk({t, "_res"}, bus.result, e.res);
          chk({t, "_fl"}, 128'(bus.rflags), 128'(e.fl));
          chk({t, "_br"}, 128'(bus.branch), 128'(e.br));
          if (e.br)
            chk({t, "_rip"}, 128'(bus.branch_rip), 128'(e.rip));
        end
      end
    end
  end

  localparam logic [9:0] OPS [13] = '{
    10'h001, 10'h029, 10'h039, 10'h021, 10'h009, 10'h031, 10'h085,
    10'h089, 10'h0C1, 10'h0D3, 10'h090, 10'h050, 10'h058
  };

  initial begin
    logic [9:0]  op;
    logic [63:0] ra, rb;
    n_checks = 0; n_errors = 0;
    mon_en = 1'b0; m_fl = 64'h2;
    reset = 1'b1;
    bus.enable = 1'b0; bus.blocked = 1'b0; bus.opcode = '0;
    bus.a = '0; bus.b = '0; bus.c = '0; bus.next_rip = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_res", bus.result, 128'd0);
    chk("rst_fl", 128'(bus.rflags), 128'h2);
    chk("rst_mv", 128'(bus.mem_valid), 128'd0);
    chk("rst_br", 128'(bus.branch), 128'd0);
    chk("rst_rip", 128'(bus.branch_rip), 128'd0);
    @(negedge clk);
    reset = 1'b0;

    // Reset arriving while an ADD is in flight
    @(negedge clk);
    bus.enable = 1'b1; bus.opcode = 10'h001;
    bus.a = 64'hFFFF_FFFF_FFFF_FFFF; bus.b = 64'd5;
    @(posedge clk);
    #2;
    chk("pre_rst_mv", 128'(bus.mem_valid), 128'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_res", bus.result, 128'd0);
    chk("mid_rst_fl", 128'(bus.rflags), 128'h2);
    chk("mid_rst_mv", 128'(bus.mem_valid), 128'd0);
    @(negedge clk);
    bus.enable = 1'b0;
    reset = 1'b0;
    mon_en = 1'b1;

    issue("add_wrap", 10'h001, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, 0);
    issue("sub_ov", 10'h029, 64'h8000_0000_0000_0000, 64'd1, 0, 0);
    issue("jo", 10'h070, 64'h10, 0, 0, 64'h1000);
    issue("cmp_eq", 10'h039, 64'd5, 64'd5, 0, 0);
    issue("jne", 10'h075, 64'h10, 0, 0, 64'h1800);
    issue("je", 10'h074, -64'sd4, 0, 0, 64'h2000);
    issue("call", 10'h0E8, 64'h100, 0, 0, 64'h4000);
    issue("call_ind", 10'h310, 64'h55, 0, 0, 64'h4100);
    issue("shl0", 10'h0C1, 64'h1234, 0, 64'd0, 0);
    issue("shl63", 10'h0C1, 64'd3, 0, 64'd63, 0);
    issue("shr1", 10'h0D3, 64'h8000_0000_0000_0001, 0, 64'd1, 0);
    issue("unknown", 10'h3FF, 64'd9, 64'd9, 0, 0);
    issue("mul", 10'h0F7, 64'h8000_0000_0000_0000, 64'd4, 0, 0);
    issue("imul", 10'h1AF, -64'sd2, 64'd3, 0, 0);
    idle();
    idle();
    chk("idle_res", bus.result, 128'd0);
    chk("idle_mv", 128'(bus.mem_valid), 128'd0);

    issue("xor_z", 10'h031, 64'hA5, 64'hA5, 0, 0);
    issue("jmp", 10'h0E9, 64'h40, 0, 0, 64'h3000);
    // Stall for three cycles: redirect must not repeat, outputs hold
    @(negedge clk);
    mon_en = 1'b0;
    bus.blocked = 1'b1;
    bus.opcode = 10'h001; bus.a = 64'd7; bus.b = 64'd7;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("blk_br", 128'(bus.branch), 128'd0);
      chk("blk_mv", 128'(bus.mem_valid), 128'd1);
      chk("blk_res", bus.result, 128'h3000);
      chk("blk_fl", 128'(bus.rflags), 128'(m_fl));
      chk("blk_rip", 128'(bus.branch_rip), 128'h3040);
    end
    @(negedge clk);
    bus.blocked = 1'b0;
    bus.enable = 1'b0;
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    chk("unblk_mv", 128'(bus.mem_valid), 128'd0);

    for (int i = 0; i < 40; i++) begin
      if ((i % 4) == 3)
        op = 10'h070 + 10'($urandom_range(0, 15));
      else
        op = OPS[$urandom_range(0, 12)];
      ra = {$urandom, $urandom};
      rb = (i % 5 == 0) ? ra : {$urandom, $urandom};
      issue("rnd", op, ra, rb, 64'($urandom_range(0, 63)),
            {32'd0, $urandom});
    end
    idle();

    for (int i = 0; i < 20 && q.size() != 0; i++)
      @(posedge clk);
    #2;
    chk("sb_drain", 128'(q.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
